// File: rtl/uart_rx.sv
// 8N1 UART receiver driven by an oversampled tick strobe.
// Presents each well-framed byte on data with a one-clk data_ready pulse.
module uart_rx #(
  parameter int unsigned Oversampling = 8,
  parameter int unsigned DataBits     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                rxd,
  output logic [DataBits-1:0] data,
  output logic                data_ready,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(Oversampling);
  localparam int unsigned IdxW = $clog2(DataBits + 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(Oversampling / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Oversampling - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DataBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAITHIGH
  } state_t;

  state_t              state;
  logic [CntW-1:0]     cnt;
  logic [IdxW-1:0]     idx;
  logic [DataBits-1:0] shreg;
  logic                rx_meta;
  logic                rxs;

  // Two-flop synchronizer, idle-high reset so no false start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM; state only advances on tick, pulses clear every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data       <= '0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: begin
            if (!rxs) begin
              state <= START;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          START: begin
            if (cnt == CntHalf) begin
              if (!rxs) begin
                state <= DATA;
                cnt   <= '0;
                idx   <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          DATA: begin
            cnt <= cnt + CntW'(1);
            if (cnt == CntLast) begin
              shreg <= {rxs, shreg[DataBits-1:1]};
              idx   <= idx + IdxW'(1);
              if (idx == IdxLast) begin
                state <= STOP;
                cnt   <= '0;
              end
            end
          end
          STOP: begin
            if (cnt == CntLast) begin
              if (rxs) begin
                data       <= shreg;
                data_ready <= 1'b1;
                state      <= IDLE;
                busy       <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= WAITHIGH;
              end
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          WAITHIGH: begin
            // A held-low line (break) must not decode as 0x00 frames.
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, corner-case sequences
// and randomized bytes at +/-3% bit-rate error against an event-queue model.
module tb_uart_rx;

  localparam int ClkPer = 100;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       rxd;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_err;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;
  int tick_div = 4;
  int tick_cnt = 0;
  logic [7:0] last_good = 8'h00;
  logic       prev_dr = 1'b0;
  logic       prev_fe = 1'b0;
  logic [8:0] obs[$];

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       exp_rdy;
    logic [7:0] exp_d;
  } vec_t;
  vec_t vecs[7];

  uart_rx #(.Oversampling(8), .DataBits(8)) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .rxd(rxd),
    .data(data),
    .data_ready(data_ready),
    .frame_err(frame_err),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #(ClkPer / 2) clk = ~clk;
  end

  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_cnt = (tick_cnt + 1) % tick_div;
      tick = (tick_cnt == 0);
    end
  end

  initial begin
    #(90000 * ClkPer);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Observed output events: {1=data_ready/0=frame_err, data}.
  always @(negedge clk) begin
    if (!rst && (data_ready || frame_err)) begin
      chk("pulse_exclusive", 32'(data_ready & frame_err), 32'd0);
      if (data_ready) begin
        chk("ready_width", 32'(prev_dr), 32'd0);
        obs.push_back({1'b1, data});
      end
      if (frame_err) begin
        chk("ferr_width", 32'(prev_fe), 32'd0);
        obs.push_back({1'b0, data});
      end
    end
    prev_dr = data_ready;
    prev_fe = frame_err;
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
    rxd = 1'b0;
    #(p);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      #(p);
    end
    rxd = stop;
    #(p);
  endtask

  task automatic check_event(input logic exp_rdy, input logic [7:0] exp_d, input string name);
    logic [8:0] ev;
    for (int i = 0; i < 64 && obs.size() == 0; i++) @(negedge clk);
    if (obs.size() == 0) begin
      chk({name, "_present"}, 32'd0, 32'd1);
    end else begin
      ev = obs.pop_front();
      chk({name, "_kind"}, 32'(ev[8]), 32'(exp_rdy));
      chk({name, "_data"}, 32'(ev[7:0]), 32'(exp_d));
    end
  endtask

  initial begin
    int p;
    logic [7:0] rb;
    int rates[2];

    vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81};
    vecs[3] = '{8'h7E, 1'b0, 1'b0, 8'h81};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 8'h3C};
    vecs[5] = '{8'hA5, 1'b0, 1'b0, 8'h3C};
    vecs[6] = '{8'h5A, 1'b1, 1'b1, 8'h5A};

    rst = 1'b1;
    rxd = 1'b1;
    p = 8 * tick_div * ClkPer;
    repeat (5) @(posedge clk);
    #2;
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_ready", 32'(data_ready), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #(p);

    // Nominal 0x55 with busy during and after the frame.
    fork
      send_frame(8'h55, 1'b1, p);
      begin
        #(3 * p);
        chk("nominal_busy_mid", 32'(busy), 32'd1);
      end
    join
    chk("nominal_busy_end", 32'(busy), 32'd0);
    check_event(1'b1, 8'h55, "nominal");
    #(p);

    // Start glitch: low for 2 ticks only.
    rxd = 1'b0;
    #(2 * tick_div * ClkPer);
    chk("glitch_busy_rise", 32'(busy), 32'd1);
    rxd = 1'b1;
    #(p);
    chk("glitch_busy_fall", 32'(busy), 32'd0);
    chk("glitch_no_event", 32'(obs.size()), 32'd0);
    chk("glitch_data", 32'(data), 32'h55);

    // Framing error followed by a break, then a good frame.
    send_frame(8'h55, 1'b1, p);
    check_event(1'b1, 8'h55, "ferr_pre");
    send_frame(8'hA3, 1'b0, p);
    #(3 * p);
    chk("ferr_event_count", 32'(obs.size()), 32'd1);
    check_event(1'b0, 8'h55, "ferr");
    chk("ferr_busy_break", 32'(busy), 32'd1);
    rxd = 1'b1;
    #(p);
    chk("ferr_busy_idle", 32'(busy), 32'd0);
    send_frame(8'h3C, 1'b1, p);
    check_event(1'b1, 8'h3C, "ferr_post");

    // Back-to-back frames with a single stop bit.
    send_frame(8'h00, 1'b1, p);
    check_event(1'b1, 8'h00, "b2b_first");
    send_frame(8'hFF, 1'b1, p);
    check_event(1'b1, 8'hFF, "b2b_second");
    #(p);

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].b, vecs[i].stop, p);
      check_event(vecs[i].exp_rdy, vecs[i].exp_d, $sformatf("vec%0d", i));
      if (!vecs[i].stop) begin
        rxd = 1'b1;
        #(p);
      end
    end
    #(p);

    // Reset asserted in the middle of data bit 4, held until frame end.
    fork
      send_frame(8'hE6, 1'b1, p);
      begin
        #(5 * p + p / 2 + 37);
        rst = 1'b1;
        #1;
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_ready", 32'(data_ready), 32'd0);
        chk("midrst_ferr", 32'(frame_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
      end
    join
    @(posedge clk);
    #1;
    rst = 1'b0;
    #(2 * p);
    chk("midrst_no_event", 32'(obs.size()), 32'd0);
    send_frame(8'h3C, 1'b1, p);
    check_event(1'b1, 8'h3C, "midrst_post");
    #(p);

    // Random bytes with the transmitter at +3% then -3% bit period.
    tick_div = 2;
    #(4 * ClkPer);
    rates[0] = 1648;
    rates[1] = 1552;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) begin
        rb = 8'($urandom_range(0, 255));
        send_frame(rb, 1'b1, rates[r]);
        check_event(1'b1, rb, $sformatf("rate%0d_byte%0d", r, i));
        #($urandom_range(0, 1) * rates[r]);
      end
    end
    #(20 * ClkPer);
    chk("final_no_extra_events", 32'(obs.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
